// File: rtl/fft_result_streamer.sv
// Streams N_POINTS FFT result words from the sample RAM as an AXI-Stream master, in natural frequency order.
// Latency: first beat 3 cycles after start (accept, read, capture); one beat per cycle when m_tready is held high.
// Backpressure: a read is issued only while buffered plus in-flight words stay below 2, so stalls never overflow.

module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_vld,
    input  logic [W-1:0]                   push_dat,
    input  logic                           pop_rdy,
    output logic                           pop_vld,
    output logic [W-1:0]                   pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign pop     = pop_vld && pop_rdy;

    // Caller guarantees no push while full; storage resets so the head reads 0 when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module fft_result_streamer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LOG2_N = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bitrev_en,
    output logic              busy,
    output logic              done,
    output logic              ram_mode,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_read,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] N_POINTS = {1'b1, {LOG2_N{1'b0}}};
    localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {LOG2_N{1'b1}}};

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             bitrev_q;
    logic             rd_pend;
    logic [1:0]       fifo_cnt;
    logic [2:0]       pending;
    logic             pop;

    function automatic logic [LOG2_N-1:0] bit_rev(input logic [LOG2_N-1:0] v);
        for (int i = 0; i < LOG2_N; i++) bit_rev[i] = v[LOG2_N-1-i];
    endfunction

    assign pop      = m_tvalid && m_tready;
    // Words owed to the FIFO once this cycle's pop has left.
    assign pending  = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    assign ram_read = (state == ST_FETCH) && (rd_cnt < N_POINTS) && (pending < 3'd2);
    assign m_tlast  = m_tvalid && (out_cnt == LAST_IDX);

    always_comb begin
        ram_adr = '0;
        ram_adr[LOG2_N-1:0] = bitrev_q ? bit_rev(rd_cnt[LOG2_N-1:0]) : rd_cnt[LOG2_N-1:0];
    end

    sync_fifo #(.W(DATA_W), .DEPTH(2)) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_pend),
        .push_dat (ram_data),
        .pop_rdy  (m_tready),
        .pop_vld  (m_tvalid),
        .pop_dat  (m_tdata),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            bitrev_q <= 1'b0;
            rd_pend  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_mode <= 1'b0;
        end else begin
            rd_pend <= ram_read;
            if (pop) out_cnt <= out_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bitrev_q <= bitrev_en;
                        rd_cnt   <= '0;
                        out_cnt  <= '0;
                        busy     <= 1'b1;
                        ram_mode <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (ram_read) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_IDX) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && (out_cnt == LAST_IDX)) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        ram_mode <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
